// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the ALU issue path: ALU control codes,
//               aluop classes, branch funct3 values, flag bit positions and
//               the branch-resolution helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes understood by the 32-bit ALU
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    // Operation classes produced by the main decoder
    localparam logic [1:0] c_aluop_mem    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_rtype  = 2'b10;
    localparam logic [1:0] c_aluop_rsvd   = 2'b11;

    // funct3 values for R/I-type arithmetic
    localparam logic [2:0] c_f3_addsub = 3'b000;
    localparam logic [2:0] c_f3_slt    = 3'b010;
    localparam logic [2:0] c_f3_or     = 3'b110;
    localparam logic [2:0] c_f3_and    = 3'b111;

    // funct3 values for conditional branches
    localparam logic [2:0] c_br_beq = 3'b000;
    localparam logic [2:0] c_br_bne = 3'b001;
    localparam logic [2:0] c_br_blt = 3'b100;
    localparam logic [2:0] c_br_bge = 3'b101;

    // Bit positions inside the packed {Z,N,V,C} flag vector
    localparam int c_flag_z = 3;
    localparam int c_flag_n = 2;
    localparam int c_flag_v = 1;
    localparam int c_flag_c = 0;

    // True when funct3 is one of the supported branch conditions
    function automatic logic branch_supported(input logic [2:0] funct3);
        return (funct3 == c_br_beq) || (funct3 == c_br_bne) ||
               (funct3 == c_br_blt) || (funct3 == c_br_bge);
    endfunction

    // Resolve a branch from the flags of the A-B subtraction.
    // Signed less-than is N^V; carry is not needed for the supported set.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic [3:0] flags);
        logic w_lt;
        logic w_taken;
        w_lt    = flags[c_flag_n] ^ flags[c_flag_v];
        w_taken = 1'b0;
        case (funct3)
            c_br_beq: w_taken = flags[c_flag_z];
            c_br_bne: w_taken = ~flags[c_flag_z];
            c_br_blt: w_taken = w_lt;
            c_br_bge: w_taken = ~w_lt;
            default:  w_taken = 1'b0;
        endcase
        return w_taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dispatch_alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Combinational ALU decoder. Maps {aluop, funct3, funct7b5,
//               opb5} onto the 3-bit ALU control code, an illegal flag and
//               a branch marker. Illegal encodings always yield ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_opb5,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal,
    output logic       o_is_branch
);

    // Decode the request class and funct fields into ALU control
    always_comb begin
        o_alu_ctrl  = c_alu_add;
        o_illegal   = 1'b0;
        o_is_branch = 1'b0;
        case (i_aluop)
            c_aluop_mem: begin
                o_alu_ctrl = c_alu_add;
            end
            c_aluop_branch: begin
                o_is_branch = 1'b1;
                if (branch_supported(i_funct3)) begin
                    o_alu_ctrl = c_alu_sub;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            c_aluop_rtype: begin
                case (i_funct3)
                    // Only a register-register op with bit 30 set is SUB;
                    // ADDI never subtracts even if its immediate has bit 30
                    c_f3_addsub: o_alu_ctrl = (i_opb5 && i_funct7b5) ? c_alu_sub : c_alu_add;
                    c_f3_slt:    o_alu_ctrl = c_alu_slt;
                    c_f3_or:     o_alu_ctrl = c_alu_or;
                    c_f3_and:    o_alu_ctrl = c_alu_and;
                    default:     o_illegal  = 1'b1;
                endcase
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch
// Description : Issue-side partner of the 32-bit ALU. Two-stage buffered
//               pipeline: stage D holds the decoded request and drives the
//               combinational ALU, stage R captures result, flags, branch
//               outcome and illegal marker. Full valid/ready backpressure
//               plus saturating retired/illegal transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    // Request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             in_opb5,
    input  logic [XLEN-1:0]  in_src_a,
    input  logic [XLEN-1:0]  in_src_b,
    // ALU interface
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_c,
    // Result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [3:0]       out_flags,
    output logic             out_taken,
    output logic             out_illegal,
    // Statistics
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Decoder outputs for the incoming request
    logic [2:0]       w_dec_ctrl;
    logic             w_dec_illegal;
    logic             w_dec_branch;

    // Stage D
    logic             r_d_valid;
    logic [XLEN-1:0]  r_d_a;
    logic [XLEN-1:0]  r_d_b;
    logic [2:0]       r_d_ctrl;
    logic             r_d_illegal;
    logic             r_d_branch;
    logic [2:0]       r_d_funct3;

    // Stage R
    logic             r_r_valid;
    logic [XLEN-1:0]  r_r_result;
    logic [3:0]       r_r_flags;
    logic             r_r_taken;
    logic             r_r_illegal;

    // Counters
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_illegal_cnt;

    // Handshake and ALU sampling
    logic             w_advance;
    logic             w_accept;
    logic             w_pop;
    logic [3:0]       w_flags;
    logic             w_taken;

    alu_ctrl_dec u_dec (
        .i_aluop     (in_aluop),
        .i_funct3    (in_funct3),
        .i_funct7b5  (in_funct7b5),
        .i_opb5      (in_opb5),
        .o_alu_ctrl  (w_dec_ctrl),
        .o_illegal   (w_dec_illegal),
        .o_is_branch (w_dec_branch)
    );

    // D moves into R whenever R is empty or being drained this cycle;
    // in_ready follows combinationally so a full pipeline still streams
    assign w_advance = r_d_valid && (!r_r_valid || out_ready);
    assign in_ready  = !r_d_valid || w_advance;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = r_r_valid && out_ready;

    // The ALU is combinational: its flags for the D-stage op are valid now
    assign w_flags = {alu_z, alu_n, alu_v, alu_c};
    assign w_taken = r_d_branch && !r_d_illegal && branch_taken(r_d_funct3, w_flags);

    assign alu_a    = r_d_a;
    assign alu_b    = r_d_b;
    assign alu_ctrl = r_d_ctrl;

    assign out_valid   = r_r_valid;
    assign out_result  = r_r_result;
    assign out_flags   = r_r_flags;
    assign out_taken   = r_r_taken;
    assign out_illegal = r_r_illegal;
    assign retired_cnt = r_retired;
    assign illegal_cnt = r_illegal_cnt;

    // Stage D: capture a new request or empty out once it has advanced
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_valid   <= 1'b0;
            r_d_a       <= '0;
            r_d_b       <= '0;
            r_d_ctrl    <= c_alu_add;
            r_d_illegal <= 1'b0;
            r_d_branch  <= 1'b0;
            r_d_funct3  <= 3'b000;
        end else if (w_accept) begin
            r_d_valid   <= 1'b1;
            r_d_a       <= in_src_a;
            r_d_b       <= in_src_b;
            r_d_ctrl    <= w_dec_ctrl;
            r_d_illegal <= w_dec_illegal;
            r_d_branch  <= w_dec_branch;
            r_d_funct3  <= in_funct3;
        end else if (w_advance) begin
            r_d_valid   <= 1'b0;
        end
    end

    // Stage R: sample the ALU on advance, hold while stalled, clear on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r_valid   <= 1'b0;
            r_r_result  <= '0;
            r_r_flags   <= 4'b0000;
            r_r_taken   <= 1'b0;
            r_r_illegal <= 1'b0;
        end else if (w_advance) begin
            r_r_valid   <= 1'b1;
            // Illegal ops carry a zero result so nothing downstream uses it
            r_r_result  <= r_d_illegal ? '0 : alu_result;
            r_r_flags   <= w_flags;
            r_r_taken   <= w_taken;
            r_r_illegal <= r_d_illegal;
        end else if (w_pop) begin
            r_r_valid   <= 1'b0;
        end
    end

    // Saturating counters of completed output transfers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired     <= '0;
            r_illegal_cnt <= '0;
        end else if (w_pop) begin
            if (!(&r_retired)) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (r_r_illegal && !(&r_illegal_cnt)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
